// File: rtl/umi_arb_pkg.sv
// rtl/umi_arb_pkg.sv - shared constants and helpers for the UMI round-robin arbiter
//
// Purpose: limits and an elaboration-time ceil(log2) used to size index and
//          counter fields in umi_rr_arbiter and umi_rr_pick.
// Contents:
//   UMI_ARB_NMAX  largest supported number of requester ports
//   clog2(v)      ceil(log2(v)), never less than 1 so a field is at least 1 bit

package umi_arb_pkg;

    localparam int UMI_ARB_NMAX = 16;

    function automatic int clog2(input int v);
        int r;
        r = 0;
        for (int i = 0; i < 32; i++) begin
            if ((1 << r) < v) begin
                r = r + 1;
            end
        end
        return (r < 1) ? 1 : r;
    endfunction

endpackage

// File: rtl/umi_rr_pick.sv
// rtl/umi_rr_pick.sv - combinational rotating priority picker
//
// Purpose: finds the first set request at or after index start, wrapping at N-1 -> 0.
//          Requests are rotated so start lands at position 0, priority-encoded
//          lowest-first, and the winner is rotated back to its true index.
// Ports:
//   req    in   N    request vector
//   start  in   IW   index given highest priority (must be < N)
//   gnt    out  N    one-hot winner, zero when no request
//   index  out  IW   winner index, zero when no request
//   any    out  1    at least one request present

module umi_rr_pick
    import umi_arb_pkg::*;
#(
    parameter int N  = 4,
    parameter int IW = clog2(N)
) (
    input  logic [N-1:0]  req,
    input  logic [IW-1:0] start,
    output logic [N-1:0]  gnt,
    output logic [IW-1:0] index,
    output logic          any
);

    function automatic int wrap_add(input int base, input int k);
        int s;
        s = base + k;
        return (s >= N) ? s - N : s;
    endfunction

    logic [N-1:0] rot;

    always_comb begin
        rot = '0;
        for (int k = 0; k < N; k++) begin
            rot[k] = req[wrap_add(int'(start), k)];
        end
    end

    assign any = |rot;

    // Walk from the lowest priority upward so the last hit (lowest k) wins.
    always_comb begin
        gnt   = '0;
        index = '0;
        for (int k = N - 1; k >= 0; k--) begin
            if (rot[k]) begin
                gnt                            = '0;
                gnt[wrap_add(int'(start), k)]  = 1'b1;
                index                          = IW'(wrap_add(int'(start), k));
            end
        end
    end

endmodule

// File: rtl/umi_rr_arbiter.sv
// rtl/umi_rr_arbiter.sv - N-to-1 round-robin UMI packet arbiter with registered output
//
// Purpose: shares one valid/ready UMI packet port between N requesters. Round-robin
//          with an optional burst allowance: the current owner may take up to BURST
//          consecutive grants while it stays valid. One registered output stage gives
//          1-cycle latency at 1 packet/cycle; out_ready reaches in_ready combinationally.
// Optional feature: define UMI_ARB_STATS_EN to add saturating per-requester grant
//          counters and the stat_clear / stat_grant_cnt ports.
// Ports:
//   clk             in   1     clock
//   nreset          in   1     asynchronous active-low reset
//   in_valid        in   N     requester i has a packet
//   in_packet       in   N*UW  requester i packet at [i*UW +: UW]
//   in_ready        out  N     requester i packet accepted this cycle
//   out_valid       out  1     output register holds a packet
//   out_packet      out  UW    output packet
//   out_ready       in   1     downstream accepts out_packet
//   stat_clear      in   1     clear all grant counters (UMI_ARB_STATS_EN)
//   stat_grant_cnt  out  N*CW  per-requester grant counts (UMI_ARB_STATS_EN)

module umi_rr_arbiter
    import umi_arb_pkg::*;
#(
    parameter int N     = 4,
    parameter int UW    = 256,
    parameter int BURST = 1,
    parameter int CW    = 16
) (
    input  logic            clk,
    input  logic            nreset,
    input  logic [N-1:0]    in_valid,
    input  logic [N*UW-1:0] in_packet,
    output logic [N-1:0]    in_ready,
    output logic            out_valid,
    output logic [UW-1:0]   out_packet,
    input  logic            out_ready
`ifdef UMI_ARB_STATS_EN
    ,
    input  logic            stat_clear,
    output logic [N*CW-1:0] stat_grant_cnt
`endif
);

    localparam int IW = clog2(N);
    localparam int BW = clog2(BURST + 1);

    // An out-of-range configuration leaves the arbiter permanently idle.
    localparam bit CFG_OK = (N >= 2) && (N <= UMI_ARB_NMAX) && (BURST >= 1) && (CW >= 1);

    logic            out_valid_q, out_valid_d;
    logic [UW-1:0]   out_packet_q, out_packet_d;
    logic [IW-1:0]   owner_q, owner_d;
    logic [BW-1:0]   burst_cnt_q, burst_cnt_d;

    logic            load_en;
    logic            keep;
    logic [IW-1:0]   pick_start;
    logic [N-1:0]    pick_gnt;
    logic [IW-1:0]   pick_idx;
    logic            pick_any;
    logic [N-1:0]    grant;
    logic [IW-1:0]   grant_idx;
    logic            grant_any;

    // nreset gates loading so in_ready is low for the whole reset window,
    // not just once the registers have cleared.
    assign load_en    = CFG_OK & nreset & (~out_valid_q | out_ready);
    assign keep       = in_valid[owner_q] & (int'(burst_cnt_q) < BURST);
    assign pick_start = (int'(owner_q) == N - 1) ? '0 : owner_q + IW'(1);

    umi_rr_pick #(
        .N  (N),
        .IW (IW)
    ) u_pick (
        .req   (in_valid),
        .start (pick_start),
        .gnt   (pick_gnt),
        .index (pick_idx),
        .any   (pick_any)
    );

    always_comb begin
        grant     = '0;
        grant_idx = owner_q;
        grant_any = 1'b0;
        if (load_en) begin
            if (keep) begin
                grant[owner_q] = 1'b1;
                grant_any      = 1'b1;
            end else if (pick_any) begin
                grant     = pick_gnt;
                grant_idx = pick_idx;
                grant_any = 1'b1;
            end
        end
    end

    assign in_ready = grant;

    always_comb begin
        out_valid_d  = out_valid_q;
        out_packet_d = out_packet_q;
        owner_d      = owner_q;
        burst_cnt_d  = burst_cnt_q;
        if (grant_any) begin
            out_valid_d  = 1'b1;
            out_packet_d = in_packet[grant_idx*UW +: UW];
            if (grant_idx == owner_q) begin
                // A lone owner re-picked by the search keeps being granted; the
                // count just stays pinned at BURST instead of overflowing.
                if (int'(burst_cnt_q) < BURST) begin
                    burst_cnt_d = burst_cnt_q + BW'(1);
                end
            end else begin
                owner_d     = grant_idx;
                burst_cnt_d = BW'(1);
            end
        end else if (out_valid_q & out_ready) begin
            out_valid_d = 1'b0;
        end
    end

    // Owner resets to N-1 so the first search starts at input 0.
    always_ff @(posedge clk or negedge nreset) begin
        if (!nreset) begin
            out_valid_q  <= 1'b0;
            out_packet_q <= '0;
            owner_q      <= IW'(N - 1);
            burst_cnt_q  <= BW'(BURST);
        end else begin
            out_valid_q  <= out_valid_d;
            out_packet_q <= out_packet_d;
            owner_q      <= owner_d;
            burst_cnt_q  <= burst_cnt_d;
        end
    end

    assign out_valid  = out_valid_q;
    assign out_packet = out_packet_q;

`ifdef UMI_ARB_STATS_EN
    logic [CW-1:0] cnt_q [N];
    logic [CW-1:0] cnt_d [N];

    always_comb begin
        for (int i = 0; i < N; i++) begin
            cnt_d[i] = cnt_q[i];
            if (stat_clear) begin
                cnt_d[i] = '0;
            end else if (in_valid[i] & in_ready[i] & ~(&cnt_q[i])) begin
                cnt_d[i] = cnt_q[i] + CW'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge nreset) begin
        if (!nreset) begin
            for (int i = 0; i < N; i++) begin
                cnt_q[i] <= '0;
            end
        end else begin
            for (int i = 0; i < N; i++) begin
                cnt_q[i] <= cnt_d[i];
            end
        end
    end

    for (genvar g = 0; g < N; g++) begin : g_stat_pack
        assign stat_grant_cnt[g*CW +: CW] = cnt_q[g];
    end
`endif

endmodule
